// File: rtl/branch_pkg.sv
// Shared definitions for the branch prediction slice: branch funct3 codes,
// 2-bit counter encodings and helpers for table field widths.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [1:0] STRONG_NT = 2'd0;
  localparam logic [1:0] WEAK_NT   = 2'd1;
  localparam logic [1:0] WEAK_T    = 2'd2;
  localparam logic [1:0] STRONG_T  = 2'd3;

  // Entry = {valid, tag, target, counter}; index/tag split of a word-aligned PC
  function automatic int idx_width(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_width(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

endpackage

// File: rtl/branch_target_table.sv
// Direct-mapped branch target storage: two combinational read ports (IF lookup,
// EX training) and one synchronous write port with active-low clear.
module branch_target_table import branch_pkg::*; #(
  parameter int XLEN = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W = 2,
  parameter logic [CNT_W-1:0] CNT_INIT = '0,
  parameter int IDX_W = idx_width(ENTRIES),
  parameter int TAG_W = tag_width(XLEN, ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] lu_idx,
  output logic             lu_valid,
  output logic [TAG_W-1:0] lu_tag,
  output logic [XLEN-1:0]  lu_target,
  output logic [CNT_W-1:0] lu_cnt,
  input  logic [IDX_W-1:0] ex_idx,
  output logic             ex_valid,
  output logic [TAG_W-1:0] ex_tag,
  output logic [XLEN-1:0]  ex_target,
  output logic [CNT_W-1:0] ex_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [XLEN-1:0]  wr_target,
  input  logic [CNT_W-1:0] wr_cnt
);

  logic             valid_reg  [ENTRIES];
  logic [CNT_W-1:0] cnt_reg    [ENTRIES];
  logic [TAG_W-1:0] tag_mem    [ENTRIES];
  logic [XLEN-1:0]  target_mem [ENTRIES];
  logic [ENTRIES-1:0] wr_sel;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_sel
      assign wr_sel[gi] = wr_en && (wr_idx == IDX_W'(gi));
    end
  endgenerate

  // Valid bits and counters need a clear; tag/target stay plain RAM
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (!reset) begin
        valid_reg[i] <= 1'b0;
        cnt_reg[i]   <= CNT_INIT;
      end else if (wr_sel[i]) begin
        valid_reg[i] <= 1'b1;
        cnt_reg[i]   <= wr_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      tag_mem[wr_idx]    <= wr_tag;
      target_mem[wr_idx] <= wr_target;
    end
  end

  assign lu_valid  = valid_reg[lu_idx];
  assign lu_tag    = tag_mem[lu_idx];
  assign lu_target = target_mem[lu_idx];
  assign lu_cnt    = cnt_reg[lu_idx];
  assign ex_valid  = valid_reg[ex_idx];
  assign ex_tag    = tag_mem[ex_idx];
  assign ex_target = target_mem[ex_idx];
  assign ex_cnt    = cnt_reg[ex_idx];

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution and prediction: IF-stage table lookup, EX-stage compare,
// mispredict redirect/flush, table training and statistics.
module branch_predict_unit import branch_pkg::*; #(
  parameter int XLEN = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W = 2,
  parameter int STAT_W = 32,
  parameter int PRED_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   IF_PC,
  output logic              IF_BPred,
  output logic              IF_BPredValid,
  output logic [XLEN-1:0]   IF_BPredTarget,
  input  logic              ID_EX_Valid,
  input  logic              ID_EX_Branch,
  input  logic              ID_EX_Jump,
  input  logic [2:0]        ID_EX_funct3,
  input  logic [XLEN-1:0]   ID_EX_PC,
  input  logic [XLEN-1:0]   ResultA,
  input  logic [XLEN-1:0]   ResultB,
  input  logic [XLEN-1:0]   ALUResult,
  input  logic              ID_EX_BPred,
  input  logic              ID_EX_BPredValid,
  input  logic [XLEN-1:0]   ID_EX_BPredTarget,
  output logic              PCSrc,
  output logic [XLEN-1:0]   PC_Branch,
  output logic [XLEN-1:0]   Rd_data,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Flush,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX_W = idx_width(ENTRIES);
  localparam int TAG_W = tag_width(XLEN, ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_WEAK_T - CNT_W'(1);
  localparam logic PRED_ON = (PRED_EN != 0);

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_pc_tag, lu_tag, ex_tag;
  logic [XLEN-1:0]  lu_target, ex_target, wr_target;
  logic [CNT_W-1:0] lu_cnt, ex_cnt, wr_cnt;
  logic lu_valid, ex_valid, wr_en;
  logic if_hit, ex_hit, cond_taken, taken, pred_taken, resolve, mispredict;
  logic [STAT_W-1:0] branch_count_reg, branch_count_next;
  logic [STAT_W-1:0] mispredict_count_reg, mispredict_count_next;
  logic unused_pc_bits;

  assign if_idx    = IF_PC[IDX_W+1:2];
  assign if_tag    = IF_PC[XLEN-1:IDX_W+2];
  assign ex_idx    = ID_EX_PC[IDX_W+1:2];
  assign ex_pc_tag = ID_EX_PC[XLEN-1:IDX_W+2];
  assign unused_pc_bits = &{1'b0, IF_PC[1:0]};

  branch_target_table #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W), .CNT_INIT(CNT_WEAK_NT)
  ) u_table (
    .clk(clk), .reset(reset),
    .lu_idx(if_idx), .lu_valid(lu_valid), .lu_tag(lu_tag),
    .lu_target(lu_target), .lu_cnt(lu_cnt),
    .ex_idx(ex_idx), .ex_valid(ex_valid), .ex_tag(ex_tag),
    .ex_target(ex_target), .ex_cnt(ex_cnt),
    .wr_en(wr_en), .wr_idx(ex_idx), .wr_tag(ex_pc_tag),
    .wr_target(wr_target), .wr_cnt(wr_cnt)
  );

  assign if_hit         = PRED_ON && reset && lu_valid && (lu_tag == if_tag);
  assign IF_BPredValid  = if_hit;
  assign IF_BPred       = if_hit && lu_cnt[CNT_W-1];
  assign IF_BPredTarget = if_hit ? lu_target : '0;

  always_comb begin
    cond_taken = 1'b0;
    case (ID_EX_funct3)
      BEQ:     cond_taken = (ResultA == ResultB);
      BNE:     cond_taken = (ResultA != ResultB);
      BLT:     cond_taken = ($signed(ResultA) < $signed(ResultB));
      BGE:     cond_taken = ($signed(ResultA) >= $signed(ResultB));
      BLTU:    cond_taken = (ResultA < ResultB);
      BGEU:    cond_taken = (ResultA >= ResultB);
      default: cond_taken = 1'b0;
    endcase
  end

  // Static not-taken mode ignores any prediction carried down the pipe
  assign resolve    = reset && ID_EX_Valid && (ID_EX_Branch || ID_EX_Jump);
  assign taken      = ID_EX_Jump || cond_taken;
  assign pred_taken = PRED_ON && ID_EX_BPredValid && ID_EX_BPred;
  assign mispredict = resolve && ((taken != pred_taken) ||
                      (taken && pred_taken && (ID_EX_BPredTarget != ALUResult)));

  assign PCSrc       = mispredict;
  assign IF_ID_Flush = mispredict;
  assign ID_EX_Flush = mispredict;
  assign PC_Branch   = !mispredict ? '0 : (taken ? ALUResult : ID_EX_PC + XLEN'(4));
  assign Rd_data     = (reset && ID_EX_Valid && ID_EX_Jump) ? ID_EX_PC + XLEN'(4) : '0;

  assign ex_hit = ex_valid && (ex_tag == ex_pc_tag);

  always_comb begin
    wr_en     = 1'b0;
    wr_target = ex_target;
    wr_cnt    = ex_cnt;
    if (PRED_ON && resolve && (ex_hit || taken)) begin
      wr_en = 1'b1;
      if (taken) wr_target = ALUResult;
      if (ID_EX_Jump)       wr_cnt = CNT_MAX;
      else if (!ex_hit)     wr_cnt = CNT_WEAK_T;
      else if (taken)       wr_cnt = (ex_cnt == CNT_MAX) ? ex_cnt : ex_cnt + CNT_W'(1);
      else                  wr_cnt = (ex_cnt == '0) ? ex_cnt : ex_cnt - CNT_W'(1);
    end
  end

  assign branch_count_next     = branch_count_reg + STAT_W'(resolve);
  assign mispredict_count_next = mispredict_count_reg + STAT_W'(mispredict);

  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      branch_count_reg     <= branch_count_next;
      mispredict_count_reg <= mispredict_count_next;
    end
  end

  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus
// randomized traffic against a table-level reference model.
module tb_branch_predict_unit;

  localparam int ENTRIES = 64;
  localparam int CNT_W = 2;
  localparam int IW = $clog2(ENTRIES);
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam logic [2:0] F_BEQ = 3'b000, F_BLT = 3'b100, F_BLTU = 3'b110;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] IF_PC, IF_BPredTarget, ID_EX_PC, ResultA, ResultB, ALUResult, ID_EX_BPredTarget;
  logic IF_BPred, IF_BPredValid, ID_EX_Valid, ID_EX_Branch, ID_EX_Jump;
  logic [2:0] ID_EX_funct3;
  logic ID_EX_BPred, ID_EX_BPredValid;
  logic PCSrc, IF_ID_Flush, ID_EX_Flush;
  logic [31:0] PC_Branch, Rd_data, branch_count, mispredict_count;

  int checks = 0;
  int fails = 0;

  // Reference model: per-index record of the last PC written there
  bit          m_valid [ENTRIES];
  logic [31:0] m_pc    [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];
  logic [31:0] m_bc, m_mc;
  bit p_we, p_res, p_red;
  int p_idx, p_cnt;
  logic [31:0] p_pc, p_tgt;
  bit e_pcsrc, e_hit, e_pred;
  logic [31:0] e_pcb, e_rd, e_ptgt;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk(clk), .reset(reset), .IF_PC(IF_PC), .IF_BPred(IF_BPred),
    .IF_BPredValid(IF_BPredValid), .IF_BPredTarget(IF_BPredTarget),
    .ID_EX_Valid(ID_EX_Valid), .ID_EX_Branch(ID_EX_Branch), .ID_EX_Jump(ID_EX_Jump),
    .ID_EX_funct3(ID_EX_funct3), .ID_EX_PC(ID_EX_PC), .ResultA(ResultA),
    .ResultB(ResultB), .ALUResult(ALUResult), .ID_EX_BPred(ID_EX_BPred),
    .ID_EX_BPredValid(ID_EX_BPredValid), .ID_EX_BPredTarget(ID_EX_BPredTarget),
    .PCSrc(PCSrc), .PC_Branch(PC_Branch), .Rd_data(Rd_data),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit cmp_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_peek(input logic [31:0] pc, output bit hit, output bit pred, output logic [31:0] tgt);
    int i;
    i = idx_of(pc);
    hit  = m_valid[i] && ((m_pc[i] >> (IW + 2)) == (pc >> (IW + 2)));
    pred = hit && (m_cnt[i] >= (1 << (CNT_W - 1)));
    tgt  = hit ? m_tgt[i] : 32'h0;
  endtask

  task automatic model_eval();
    bit resolve, taken, pt, hit, pr;
    logic [31:0] t;
    int c;
    e_pcsrc = 0; e_pcb = 0; e_rd = 0; e_hit = 0; e_pred = 0; e_ptgt = 0;
    p_we = 0; p_res = 0; p_red = 0;
    if (!reset) return;
    model_peek(IF_PC, e_hit, e_pred, e_ptgt);
    resolve = ID_EX_Valid && (ID_EX_Branch || ID_EX_Jump);
    taken = ID_EX_Jump ? 1'b1 : cmp_taken(ID_EX_funct3, ResultA, ResultB);
    pt = ID_EX_BPredValid && ID_EX_BPred;
    e_pcsrc = resolve && ((taken && !pt) || (!taken && pt) ||
              (taken && pt && ID_EX_BPredTarget != ALUResult));
    e_pcb = !e_pcsrc ? 32'h0 : (taken ? ALUResult : ID_EX_PC + 32'd4);
    e_rd = (ID_EX_Valid && ID_EX_Jump) ? ID_EX_PC + 32'd4 : 32'h0;
    p_res = resolve;
    p_red = e_pcsrc;
    model_peek(ID_EX_PC, hit, pr, t);
    p_idx = idx_of(ID_EX_PC);
    c = m_cnt[p_idx];
    p_we = resolve && (hit || taken);
    p_pc = ID_EX_PC;
    p_tgt = taken ? ALUResult : t;
    if (ID_EX_Jump) p_cnt = CMAX;
    else if (!hit) p_cnt = 1 << (CNT_W - 1);
    else if (taken) p_cnt = (c < CMAX) ? c + 1 : CMAX;
    else p_cnt = (c > 0) ? c - 1 : 0;
  endtask

  task automatic model_commit();
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 0; m_pc[i] = 0; m_tgt[i] = 0; m_cnt[i] = (1 << (CNT_W - 1)) - 1;
      end
      m_bc = 0; m_mc = 0;
    end else begin
      if (p_we) begin
        m_valid[p_idx] = 1; m_pc[p_idx] = p_pc; m_tgt[p_idx] = p_tgt; m_cnt[p_idx] = p_cnt;
      end
      if (p_res) m_bc = m_bc + 1;
      if (p_red) m_mc = m_mc + 1;
    end
  endtask

  // Drive one cycle of stimulus just after a rising edge; outputs settle by +3
  task automatic drive(input bit v, input bit br, input bit j, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] tgt, input bit bp, input bit bpv,
                       input logic [31:0] bpt, input logic [31:0] ifpc);
    ID_EX_Valid = v; ID_EX_Branch = br; ID_EX_Jump = j; ID_EX_funct3 = f3;
    ID_EX_PC = pc; ResultA = a; ResultB = b; ALUResult = tgt;
    ID_EX_BPred = bp; ID_EX_BPredValid = bpv; ID_EX_BPredTarget = bpt; IF_PC = ifpc;
    model_eval();
    #3;
  endtask

  task automatic idle(input logic [31:0] ifpc);
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, ifpc);
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1, 0, 1, 3'd0, 32'h200, 32'h0, 32'h0, 32'h300, 0, 0, 32'h0, 32'h100);
    checks++;
    if ({PCSrc, IF_ID_Flush, ID_EX_Flush, IF_BPredValid, IF_BPred} !== 5'b0 ||
        PC_Branch !== 32'h0 || Rd_data !== 32'h0 || IF_BPredTarget !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: got pcsrc=%b pcb=%h rd=%h ifv=%b required all 0", PCSrc, PC_Branch, Rd_data, IF_BPredValid);
    end
    tick(); tick();
    reset = 1'b1;
    idle(32'h100);
    checks++;
    if (IF_BPredValid !== 1'b0) begin fails++; $display("FAIL reset_lookup: got valid=%b required 0", IF_BPredValid); end
    checks++;
    if (branch_count !== 32'h0 || mispredict_count !== 32'h0) begin
      fails++; $display("FAIL reset_stats: got %0d/%0d required 0/0", branch_count, mispredict_count);
    end
    tick();
  endtask

  task automatic test_beq_train();
    drive(1, 1, 0, F_BEQ, 32'h100, 32'd5, 32'd5, 32'h180, 0, 0, 32'h0, 32'h100);
    checks++;
    if ({PCSrc, IF_ID_Flush, ID_EX_Flush} !== 3'b111 || PC_Branch !== 32'h180) begin
      fails++; $display("FAIL beq_redirect: got flags=%b pcb=%h required 111 00000180", {PCSrc, IF_ID_Flush, ID_EX_Flush}, PC_Branch);
    end
    tick();
    idle(32'h100);
    checks++;
    if ({IF_BPredValid, IF_BPred} !== 2'b11 || IF_BPredTarget !== 32'h180) begin
      fails++; $display("FAIL beq_alloc: got v/p=%b tgt=%h required 11 00000180", {IF_BPredValid, IF_BPred}, IF_BPredTarget);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 0, F_BEQ, 32'h100, 32'd5, 32'd5, 32'h180, 1, 1, 32'h180, 32'h0);
      checks++;
      if (PCSrc !== 1'b0 || PC_Branch !== 32'h0) begin
        fails++; $display("FAIL beq_correct%0d: got pcsrc=%b pcb=%h required 0 0", k, PCSrc, PC_Branch);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 0, F_BEQ, 32'h100, 32'd5, 32'd6, 32'h180, 1, 1, 32'h180, 32'h0);
      checks++;
      if (PCSrc !== 1'b1 || PC_Branch !== 32'h104) begin
        fails++; $display("FAIL beq_nt%0d: got pcsrc=%b pcb=%h required 1 00000104", k, PCSrc, PC_Branch);
      end
      tick();
      idle(32'h100);
      checks++;
      if ({IF_BPredValid, IF_BPred} !== ((k == 0) ? 2'b11 : 2'b10)) begin
        fails++; $display("FAIL beq_cnt%0d: got v/p=%b required %b", k, {IF_BPredValid, IF_BPred}, (k == 0) ? 2'b11 : 2'b10);
      end
      tick();
    end
  endtask

  task automatic test_signed_unsigned();
    drive(1, 1, 0, F_BLT, 32'h140, 32'hFFFF_FFFF, 32'd1, 32'h1C0, 0, 0, 32'h0, 32'h0);
    checks++;
    if (PCSrc !== 1'b1 || PC_Branch !== 32'h1C0) begin
      fails++; $display("FAIL blt_taken: got pcsrc=%b pcb=%h required 1 000001c0", PCSrc, PC_Branch);
    end
    tick();
    drive(1, 1, 0, F_BLTU, 32'h148, 32'hFFFF_FFFF, 32'd1, 32'h1C0, 0, 0, 32'h0, 32'h140);
    checks++;
    if (PCSrc !== 1'b0 || IF_BPredValid !== 1'b1) begin
      fails++; $display("FAIL bltu_nt: got pcsrc=%b lookup140=%b required 0 1", PCSrc, IF_BPredValid);
    end
    tick();
    idle(32'h148);
    checks++;
    if (IF_BPredValid !== 1'b0) begin fails++; $display("FAIL bltu_noalloc: got valid=%b required 0", IF_BPredValid); end
    tick();
  endtask

  task automatic test_jal();
    drive(1, 0, 1, 3'd0, 32'h200, 32'h0, 32'h0, 32'h2F0, 0, 0, 32'h0, 32'h0);
    checks++;
    if (PCSrc !== 1'b1 || PC_Branch !== 32'h2F0 || Rd_data !== 32'h204) begin
      fails++; $display("FAIL jal_first: got pcsrc=%b pcb=%h rd=%h required 1 000002f0 00000204", PCSrc, PC_Branch, Rd_data);
    end
    tick();
    idle(32'h200);
    checks++;
    if ({IF_BPredValid, IF_BPred} !== 2'b11 || IF_BPredTarget !== 32'h2F0) begin
      fails++; $display("FAIL jal_alloc: got v/p=%b tgt=%h required 11 000002f0", {IF_BPredValid, IF_BPred}, IF_BPredTarget);
    end
    tick();
    drive(1, 0, 1, 3'd0, 32'h200, 32'h0, 32'h0, 32'h300, 1, 1, 32'h2F0, 32'h0);
    checks++;
    if ({PCSrc, IF_ID_Flush, ID_EX_Flush} !== 3'b111 || PC_Branch !== 32'h300 || Rd_data !== 32'h204) begin
      fails++; $display("FAIL jal_stale: got flags=%b pcb=%h rd=%h required 111 00000300 00000204", {PCSrc, IF_ID_Flush, ID_EX_Flush}, PC_Branch, Rd_data);
    end
    tick();
    drive(1, 0, 1, 3'd0, 32'h200, 32'h0, 32'h0, 32'h300, 1, 1, 32'h300, 32'h200);
    checks++;
    if ({PCSrc, IF_ID_Flush, ID_EX_Flush} !== 3'b000 || Rd_data !== 32'h204 || IF_BPredTarget !== 32'h300) begin
      fails++; $display("FAIL jal_repeat: got flags=%b rd=%h tgt=%h required 000 00000204 00000300", {PCSrc, IF_ID_Flush, ID_EX_Flush}, Rd_data, IF_BPredTarget);
    end
    tick();
    idle(32'h0);
    checks++;
    if (branch_count !== 32'd12 || mispredict_count !== 32'd6) begin
      fails++; $display("FAIL stats: got %0d/%0d required 12/6", branch_count, mispredict_count);
    end
    tick();
  endtask

  task automatic test_alias();
    drive(1, 1, 0, F_BEQ, 32'h100, 32'd7, 32'd7, 32'h180, 0, 0, 32'h0, 32'h100);
    checks++;
    if (IF_BPredValid !== 1'b0 || PCSrc !== 1'b1) begin
      fails++; $display("FAIL alias_replaced: got lookup=%b pcsrc=%b required 0 1", IF_BPredValid, PCSrc);
    end
    tick();
    idle(32'h100 + ENTRIES * 4);
    checks++;
    if (IF_BPredValid !== 1'b0) begin fails++; $display("FAIL alias_evict: got valid=%b required 0", IF_BPredValid); end
    tick();
    idle(32'h100);
    checks++;
    if ({IF_BPredValid, IF_BPred} !== 2'b11 || IF_BPredTarget !== 32'h180) begin
      fails++; $display("FAIL alias_new: got v/p=%b tgt=%h required 11 00000180", {IF_BPredValid, IF_BPred}, IF_BPredTarget);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    drive(1, 1, 0, F_BEQ, 32'h180, 32'd1, 32'd1, 32'h1C0, 0, 0, 32'h0, 32'h100);
    checks++;
    if (PCSrc !== 1'b0 || PC_Branch !== 32'h0 || IF_BPredValid !== 1'b0) begin
      fails++; $display("FAIL midreset_out: got pcsrc=%b pcb=%h ifv=%b required 0 0 0", PCSrc, PC_Branch, IF_BPredValid);
    end
    tick();
    reset = 1'b1;
    idle(32'h100);
    checks++;
    if (IF_BPredValid !== 1'b0 || branch_count !== 32'h0 || mispredict_count !== 32'h0) begin
      fails++; $display("FAIL midreset_state: got ifv=%b stats=%0d/%0d required 0 0/0", IF_BPredValid, branch_count, mispredict_count);
    end
    tick();
    idle(32'h180);
    checks++;
    if (IF_BPredValid !== 1'b0) begin fails++; $display("FAIL midreset_discard: got valid=%b required 0", IF_BPredValid); end
    tick();
  endtask

  task automatic test_invalid();
    drive(0, 1, 0, F_BEQ, 32'h180, 32'd5, 32'd5, 32'h1C0, 0, 0, 32'h0, 32'h180);
    checks++;
    if ({PCSrc, IF_ID_Flush, ID_EX_Flush} !== 3'b000 || PC_Branch !== 32'h0 || Rd_data !== 32'h0) begin
      fails++; $display("FAIL invalid_out: got flags=%b pcb=%h rd=%h required 000 0 0", {PCSrc, IF_ID_Flush, ID_EX_Flush}, PC_Branch, Rd_data);
    end
    tick();
    idle(32'h180);
    checks++;
    if (IF_BPredValid !== 1'b0 || branch_count !== 32'h0) begin
      fails++; $display("FAIL invalid_state: got ifv=%b count=%0d required 0 0", IF_BPredValid, branch_count);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pool [8] = '{32'h100, 32'h104, 32'h200, 32'h108, 32'h300, 32'h500, 32'h10C, 32'h204};
    logic [31:0] ops [4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] tgts [3] = '{32'h400, 32'h404, 32'h500};
    logic [31:0] pc, bpt;
    bit h, p;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) != 0);
      pc = pool[$urandom_range(0, 7)];
      model_peek(pc, h, p, bpt);
      if ($urandom_range(0, 3) == 0) begin
        h = 1'($urandom); p = 1'($urandom); bpt = tgts[$urandom_range(0, 2)];
      end
      drive(($urandom_range(0, 9) != 0), 1'($urandom), ($urandom_range(0, 3) == 0),
            3'($urandom), pc, ops[$urandom_range(0, 3)], ops[$urandom_range(0, 3)],
            tgts[$urandom_range(0, 2)], p, h, bpt, pool[$urandom_range(0, 7)]);
      checks++;
      if ({PCSrc, IF_ID_Flush, ID_EX_Flush} !== {3{e_pcsrc}} || PC_Branch !== e_pcb) begin
        fails++; $display("FAIL rnd%0d_redirect: got flags=%b pcb=%h required %b %h", n, {PCSrc, IF_ID_Flush, ID_EX_Flush}, PC_Branch, {3{e_pcsrc}}, e_pcb);
      end
      checks++;
      if (Rd_data !== e_rd) begin fails++; $display("FAIL rnd%0d_link: got %h required %h", n, Rd_data, e_rd); end
      checks++;
      if ({IF_BPredValid, IF_BPred} !== {e_hit, e_pred} || IF_BPredTarget !== e_ptgt) begin
        fails++; $display("FAIL rnd%0d_lookup: got v/p=%b tgt=%h required %b %h", n, {IF_BPredValid, IF_BPred}, IF_BPredTarget, {e_hit, e_pred}, e_ptgt);
      end
      tick();
      checks++;
      if (branch_count !== m_bc || mispredict_count !== m_mc) begin
        fails++; $display("FAIL rnd%0d_stats: got %0d/%0d required %0d/%0d", n, branch_count, mispredict_count, m_bc, m_mc);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_beq_train();
    test_signed_unsigned();
    test_jal();
    test_alias();
    test_reset_mid();
    test_invalid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction unit for the RV32I pipeline. It provides a direct-mapped branch target table with 2-bit saturating counters, looked up combinationally from the IF-stage PC. It resolves branches and jumps in EX, detects direction and target mispredictions, drives the redirect and flush signals, and trains the table one clock later. It replaces the stateless EX-stage branch checker and feeds IF with predicted taken/target.

## Interface
Parameters:
- XLEN, 32, datapath and PC width
- ENTRIES, 64, table depth; power of two, ≥ 2
- CNT_W, 2, saturating counter width
- STAT_W, 32, width of the statistics counters
- PRED_EN, 1, 1 = table-based prediction; 0 = static not-taken (lookup outputs tied 0, no table updates)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- IF_PC  in  XLEN  fetch PC
- IF_BPred  out  1  predict taken (valid only with IF_BPredValid)
- IF_BPredValid  out  1  table hit for IF_PC
- IF_BPredTarget  out  XLEN  predicted target
- ID_EX_Valid  in  1  EX instruction is live (not a bubble)
- ID_EX_Branch  in  1  conditional branch in EX
- ID_EX_Jump  in  1  JAL/JALR in EX
- ID_EX_funct3  in  3  branch type
- ID_EX_PC  in  XLEN  EX instruction PC
- ResultA, ResultB  in  XLEN  forwarded compare operands
- ALUResult  in  XLEN  computed branch/jump target
- ID_EX_BPred, ID_EX_BPredValid  in  1  prediction carried down from IF
- ID_EX_BPredTarget  in  XLEN  target carried down from IF
- PCSrc  out  1  redirect fetch this cycle
- PC_Branch  out  XLEN  redirect address
- Rd_data  out  XLEN  link value (ID_EX_PC+4 on jump, else 0)
- IF_ID_Flush, ID_EX_Flush  out  1  squash younger stages
- branch_count, mispredict_count  out  STAT_W  resolved control transfers / redirects

## Operation
- Index = PC[log2(ENTRIES)+1:2]; tag = PC[XLEN-1:log2(ENTRIES)+2]. Entry = {valid, tag, target, counter}.
- Lookup: hit = valid && tag match. IF_BPred = counter MSB (for CNT_W=2: values 2 and 3 mean taken). On miss, all three IF outputs are 0.
- Resolution applies when ID_EX_Valid && (Branch || Jump). Jump has priority; a jump is always taken.
- Actual taken per funct3:
  - 000 EQ, 001 NE.
  - 100 LT signed, 101 GE signed.
  - 110 LTU, 111 GEU.
  - Any other funct3 = not taken.
- Predicted taken: pt = ID_EX_BPredValid && ID_EX_BPred.
- Mispredict if any of:
  - taken && !pt → PC_Branch = ALUResult.
  - !taken && pt → PC_Branch = ID_EX_PC+4.
  - taken && pt && ID_EX_BPredTarget ≠ ALUResult → PC_Branch = ALUResult.
- On mispredict: PCSrc = IF_ID_Flush = ID_EX_Flush = 1. A correct prediction asserts none of them.
- Update (registered, at the edge ending the resolving cycle):
  - Hit: counter +1 if taken, −1 if not, saturating at 0 and 2^CNT_W−1. Target is rewritten with ALUResult when taken.
  - Miss and taken: allocate/replace the entry with tag, target = ALUResult, counter = weakly taken (2 for CNT_W=2).
  - Miss and not taken: no allocation.
  - Jump: counter forced to max on every update.
- Statistics: branch_count +1 per resolution; mispredict_count +1 per redirect. Both wrap modulo 2^STAT_W.
- While reset is low, all combinational outputs are forced 0.

## Timing
- Lookup and resolution are zero-latency combinational.
- A table update becomes visible to lookups from the cycle after the resolving edge.
- Simultaneous lookup and update of the same index: the lookup returns the pre-update entry.
- Reset values:
  - All valid bits 0; counters weakly not-taken (1 for CNT_W=2).
  - Stat counters 0.
  - All outputs 0.
- Reset asserted mid-operation takes effect at the next edge and discards the pending update.
- ID_EX_Valid = 0: no redirect, no update, no count.
- PRED_EN = 0: the table is never written. Every taken transfer redirects; not-taken never redirects.

## Structure
- Shared package branch_pkg:
  - funct3 constants (BEQ…BGEU).
  - Counter encodings (STRONG_NT, WEAK_NT, WEAK_T, STRONG_T).
  - Entry struct/field widths.
- Sub-module branch_target_table holds the storage:
  - Combinational read port and synchronous write port.
  - Synchronous active-low clear.
- branch_predict_unit keeps compare, mispredict, redirect and update logic.

## Test plan
- After reset, lookup PC 0x100 → IF_BPredValid=0. BEQ at 0x100, A=B=5, target 0x180, not predicted → PCSrc=1, PC_Branch=0x180, both flushes=1. Next cycle lookup 0x100 → valid=1, pred=1, target 0x180.
- Same BEQ repeated taken four times → counter saturates at 3. One not-taken with pt=1 → redirect to 0x104; counter becomes 2; pred still taken.
- BLT with A=0xFFFFFFFF, B=1 → taken. BLTU with the same operands → not taken, no allocation.
- JAL at 0x200, target 0x300, hit with stale target 0x2F0 → redirect to 0x300, Rd_data=0x204. Entry target is updated; a repeat with the correct target → no flush.
- Two PCs aliasing the same index (0x100, 0x100+4·ENTRIES) → the second replaces the first. Lookup of the first misses.
- Reset pulsed low for one cycle between training and lookup → lookup misses and both stat counters read 0. ID_EX_Valid=0 with Branch=1 → no output change.
